// File: rtl/dcs_frame_ctrl.sv
// DCS transmit-chain sequencer: payload, then CRC, FEC wait, frame hold.
// Optional WAIT_FEC watchdog enabled by defining DCS_CTRL_WDOG_EN.
module dcs_frame_ctrl #(
  parameter int PAYLOAD_W = 32,
  parameter int CRC_W     = 16,
  parameter int WDOG_CYC  = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PAYLOAD_W-1:0]          in_data,
  output logic                          chain_start,
  output logic                          ser_d,
  output logic                          crc_bit,
  output logic                          mux_ctrl,
  input  logic [CRC_W-1:0]              crc_in,
  input  logic                          fec_done,
  input  logic [2*(PAYLOAD_W+CRC_W)-1:0] frame_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*(PAYLOAD_W+CRC_W)-1:0] frame_out,
  output logic                          err
);

  localparam int FW = 2 * (PAYLOAD_W + CRC_W);
  localparam int CW = $clog2(PAYLOAD_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_PAY   = 3'd2;
  localparam logic [2:0] S_CRC   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PAYLOAD_W-1:0] pay_q, pay_d;
  logic [CRC_W-1:0]     crc_q, crc_d;
  logic [FW-1:0]        frame_q, frame_d;

`ifdef DCS_CTRL_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pay_d   = pay_q;
    crc_d   = crc_q;
    frame_d = frame_q;
`ifdef DCS_CTRL_WDOG_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pay_d   = in_data;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = CW'(PAYLOAD_W - 1);
        state_d = S_PAY;
      end
      S_PAY: begin
        pay_d = {pay_q[PAYLOAD_W-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        // CRC register is final on the edge that ends the last payload bit
        if (cnt_q == '0) begin
          crc_d   = crc_in;
          cnt_d   = CW'(CRC_W - 1);
          state_d = S_CRC;
        end
      end
      S_CRC: begin
        crc_d = {crc_q[CRC_W-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_WAIT;
`ifdef DCS_CTRL_WDOG_EN
          wd_d    = '0;
`endif
        end
      end
      S_WAIT: begin
        if (fec_done) begin
          frame_d = frame_in;
          state_d = S_HOLD;
        end
`ifdef DCS_CTRL_WDOG_EN
        else if (wd_q == WW'(WDOG_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
`endif
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pay_q   <= '0;
      crc_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pay_q   <= pay_d;
      crc_q   <= crc_d;
      frame_q <= frame_d;
    end
  end

`ifdef DCS_CTRL_WDOG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready    = (state_q == S_IDLE);
  assign chain_start = (state_q == S_START);
  assign ser_d       = (state_q == S_PAY) & pay_q[PAYLOAD_W-1];
  assign mux_ctrl    = (state_q == S_CRC);
  assign crc_bit     = (state_q == S_CRC) & crc_q[CRC_W-1];
  assign out_valid   = (state_q == S_HOLD);
  assign frame_out   = frame_q;

endmodule

// File: tb/tb_dcs_frame_ctrl.sv
// Directed + randomized bench for dcs_frame_ctrl.
// Expected bits come from cycle offsets relative to the accept cycle.
module tb_dcs_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        chain_start;
  logic        ser_d;
  logic        crc_bit;
  logic        mux_ctrl;
  logic [15:0] crc_in;
  logic        fec_done;
  logic [95:0] frame_in;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] frame_out;
  logic        err;

  int total = 0;
  int bad   = 0;

  dcs_frame_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .chain_start(chain_start),
    .ser_d      (ser_d),
    .crc_bit    (crc_bit),
    .mux_ctrl   (mux_ctrl),
    .crc_in     (crc_in),
    .fec_done   (fec_done),
    .frame_in   (frame_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_out  (frame_out),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge in IDLE; offset k counts cycles after the accept cycle.
  // fd < 0: FEC never completes, returns at the last watchdog-window cycle.
  task automatic run_frame(input logic [31:0] p, input logic [15:0] c,
                           input logic [95:0] f, input int fd,
                           input int hw, input int abort_at);
    int last;
    last = (fd < 0) ? 113 : 50 + fd;
    chk("idle_rdy", 96'(in_ready), 96'd1);
    chk("idle_ov", 96'(out_valid), 96'd0);
    in_valid  = 1'b1;
    in_data   = p;
    crc_in    = ~c;
    fec_done  = 1'b1;
    out_ready = 1'b1;
    frame_in  = ~f;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_rdy", 96'(in_ready), 96'd1);
        chk("rst_cs", 96'(chain_start), 96'd0);
        chk("rst_mux", 96'(mux_ctrl), 96'd0);
        chk("rst_ov", 96'(out_valid), 96'd0);
        chk("rst_sd", 96'(ser_d), 96'd0);
        in_valid  = 1'b0;
        fec_done  = 1'b0;
        out_ready = 1'b0;
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_nocs", 96'(chain_start), 96'd0);
        return;
      end
      chk($sformatf("cs@%0d", k), 96'(chain_start), 96'(k == 1));
      chk($sformatf("sd@%0d", k), 96'(ser_d),
          96'((k >= 2 && k <= 33) ? p[33-k] : 1'b0));
      chk($sformatf("mux@%0d", k), 96'(mux_ctrl),
          96'(k >= 34 && k <= 49));
      chk($sformatf("cb@%0d", k), 96'(crc_bit),
          96'((k >= 34 && k <= 49) ? c[49-k] : 1'b0));
      chk($sformatf("rdy@%0d", k), 96'(in_ready), 96'd0);
      chk($sformatf("ov@%0d", k), 96'(out_valid), 96'd0);
      chk($sformatf("err@%0d", k), 96'(err), 96'd0);
      if (k == 33) crc_in = c;
      if (k == 34) crc_in = ~c;
      if (k == 50) begin
        fec_done  = 1'b0;
        out_ready = 1'b0;
      end
      if (fd >= 0 && k == 50 + fd) begin
        fec_done = 1'b1;
        frame_in = f;
      end
    end
    if (fd < 0) return;
    for (int h = 0; h <= hw; h++) begin
      @(negedge clk);
      if (h == 0) begin
        fec_done = 1'b0;
        frame_in = ~f;
      end
      chk($sformatf("hold_ov%0d", h), 96'(out_valid), 96'd1);
      chk($sformatf("hold_fr%0d", h), frame_out, f);
      chk($sformatf("hold_rdy%0d", h), 96'(in_ready), 96'd0);
      if (h == hw) out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_ov", 96'(out_valid), 96'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    crc_in    = '0;
    fec_done  = 1'b0;
    frame_in  = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("r_rdy", 96'(in_ready), 96'd1);
    chk("r_cs", 96'(chain_start), 96'd0);
    chk("r_mux", 96'(mux_ctrl), 96'd0);
    chk("r_ov", 96'(out_valid), 96'd0);
    chk("r_fr", frame_out, 96'd0);
    chk("r_err", 96'(err), 96'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_frame(32'h8000_0001, 16'hA5C3,
              96'h01234567_89ABCDEF_89ABCDEF, 2, 5, 0);
    for (int i = 0; i < 4; i++)
      run_frame($urandom, 16'($urandom),
                {$urandom, $urandom, $urandom},
                int'($urandom_range(0, 6)),
                int'($urandom_range(0, 4)), 0);
    run_frame($urandom, 16'($urandom), {$urandom, $urandom, $urandom},
              1, 0, 10);
    run_frame($urandom, 16'($urandom), {$urandom, $urandom, $urandom},
              3, 2, 0);

    run_frame($urandom, 16'($urandom), {$urandom, $urandom, $urandom},
              -1, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
`ifdef DCS_CTRL_WDOG_EN
    chk("wd_err", 96'(err), 96'd1);
    chk("wd_rdy", 96'(in_ready), 96'd1);
    chk("wd_ov", 96'(out_valid), 96'd0);
    repeat (5) @(negedge clk);
    chk("wd_sticky", 96'(err), 96'd1);
`else
    for (int j = 0; j < 20; j++) begin
      if (j > 0) @(negedge clk);
      chk("nowd_rdy", 96'(in_ready), 96'd0);
      chk("nowd_ov", 96'(out_valid), 96'd0);
      chk("nowd_err", 96'(err), 96'd0);
    end
`endif
    reset_n = 1'b0;
    #1;
    chk("wd_rst_err", 96'(err), 96'd0);
    chk("wd_rst_rdy", 96'(in_ready), 96'd1);
    #1 reset_n = 1'b1;
    @(negedge clk);
    run_frame($urandom, 16'($urandom), {$urandom, $urandom, $urandom},
              0, 1, 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
